// File: rtl/ascii_gen_pkg.sv
// Shared types and constants for the ASCII test stream generator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ascii_gen_pkg;

  // Generator control states; DONE is a single-cycle completion marker.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Character source selection, captured when a run starts.
  typedef enum logic {
    MODE_SEQ  = 1'b0,
    MODE_RAND = 1'b1
  } mode_e;

  // LFSR value used at reset and whenever a zero seed is supplied
  // (an all-zero Fibonacci LFSR would lock up).
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  // One step of the 16-bit Fibonacci LFSR, taps 16,14,13,11.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

endpackage

// File: rtl/test_ascii_stream_gen_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load and single-step advance.
// Latency: load/advance visible on state one cycle after the edge.
// Backpressure: none; advances only when the caller asserts advance.
module lfsr16
  import ascii_gen_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = ascii_gen_pkg::LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        advance,
  output logic [15:0] state
);

  // Load has priority over advance so a new run always starts from its seed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RESET_VAL;
    end else if (load) begin
      state <= load_value;
    end else if (advance) begin
      state <= lfsr16_next(state);
    end
  end

endmodule

// File: rtl/test_ascii_stream_gen.sv
// Emits a run of target_count ASCII characters (sequential or LFSR-random) over valid/ready.
// Latency: first character valid the cycle after execute; next one the cycle after each transfer.
// Backpressure: out_ready low holds generated_ascii and the LFSR; no characters are dropped.
module test_ascii_stream_gen #(
  parameter int          COUNT_W       = 12,
  parameter logic [7:0]  CHAR_MIN      = 8'h61,
  parameter logic [7:0]  CHAR_MAX      = 8'h7A,
  parameter logic [15:0] LFSR_SEED_DEF = ascii_gen_pkg::LFSR_SEED_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               execute,
  input  logic               abort,
  input  logic               mode,
  input  logic [15:0]        seed,
  input  logic [COUNT_W-1:0] target_count,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [7:0]         generated_ascii,
  output logic [COUNT_W-1:0] generate_count,
  output logic               busy,
  output logic               done
);

  import ascii_gen_pkg::*;

  // Number of distinct characters in the alphabet; 9 bits so a full 0..255 range fits.
  localparam logic [8:0] SPAN = 9'({1'b0, CHAR_MAX} - {1'b0, CHAR_MIN} + 9'd1);

  // Map an LFSR low byte into the CHAR_MIN..CHAR_MAX range.
  function automatic logic [7:0] rand_char(input logic [7:0] b);
    logic [8:0] m;
    m = {1'b0, b} % SPAN;
    return CHAR_MIN + m[7:0];
  endfunction

  // Sequential successor with wrap back to the bottom of the alphabet.
  function automatic logic [7:0] seq_char_next(input logic [7:0] c);
    return (c == CHAR_MAX) ? CHAR_MIN : c + 8'd1;
  endfunction

  state_e             state;
  mode_e              mode_r;
  logic [COUNT_W-1:0] target_r;
  logic [15:0]        lfsr_state;
  logic [15:0]        seed_eff;
  logic [7:0]         lfsr_nxt_lo;
  logic               start;
  logic               xfer;
  logic               last_xfer;

  // A run starts only from IDLE, and abort in the same cycle suppresses it.
  assign start     = (state == ST_IDLE) && execute && !abort;
  assign xfer      = out_valid && out_ready;
  // generate_count < target_r whenever out_valid is high, so the +1 cannot wrap.
  assign last_xfer = xfer && ((generate_count + COUNT_W'(1)) == target_r);
  assign seed_eff  = (seed == 16'h0000) ? LFSR_SEED_DEF : seed;
  // Low byte of the state the LFSR will hold after this transfer.
  assign lfsr_nxt_lo = 8'(lfsr16_next(lfsr_state));

  lfsr16 #(
    .RESET_VAL (LFSR_SEED_DEF)
  ) u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .load       (start),
    .load_value (seed_eff),
    .advance    (xfer),
    .state      (lfsr_state)
  );

  // Control FSM with registered handshake, status and character outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      mode_r          <= MODE_SEQ;
      target_r        <= '0;
      out_valid       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      generated_ascii <= CHAR_MIN;
      generate_count  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_r         <= mode_e'(mode);
            target_r       <= target_count;
            generate_count <= '0;
            if (target_count == '0) begin
              // Empty run: complete immediately without presenting a character.
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state     <= ST_RUN;
              out_valid <= 1'b1;
              busy      <= 1'b1;
              // First character derives from the value the LFSR is loading now.
              generated_ascii <= (mode_e'(mode) == MODE_RAND) ? rand_char(seed_eff[7:0])
                                                               : CHAR_MIN;
            end
          end
        end

        ST_RUN: begin
          if (xfer) begin
            generate_count  <= generate_count + COUNT_W'(1);
            generated_ascii <= (mode_r == MODE_RAND) ? rand_char(lfsr_nxt_lo)
                                                     : seq_char_next(generated_ascii);
          end
          if (abort) begin
            // Abandon the run quietly; count keeps whatever was transferred.
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (last_xfer) begin
            state     <= ST_DONE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_test_ascii_stream_gen.sv
// Self-checking bench for test_ascii_stream_gen: table of full runs plus hand-built corner sequences.
// Latency: n/a (testbench).
// Backpressure: out_ready driven per sequence (always-ready or 1-0-0-1 pattern).
module tb_test_ascii_stream_gen;

  localparam int COUNT_W = 12;

  logic               clk = 1'b0;
  logic               reset;
  logic               execute;
  logic               abort;
  logic               mode;
  logic [15:0]        seed;
  logic [COUNT_W-1:0] target_count;
  logic               out_ready;
  logic               out_valid;
  logic [7:0]         generated_ascii;
  logic [COUNT_W-1:0] generate_count;
  logic               busy;
  logic               done;

  int n_total = 0;
  int n_pass  = 0;

  test_ascii_stream_gen #(
    .COUNT_W       (COUNT_W),
    .CHAR_MIN      (8'h61),
    .CHAR_MAX      (8'h7A),
    .LFSR_SEED_DEF (16'hACE1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .execute         (execute),
    .abort           (abort),
    .mode            (mode),
    .seed            (seed),
    .target_count    (target_count),
    .out_ready       (out_ready),
    .out_valid       (out_valid),
    .generated_ascii (generated_ascii),
    .generate_count  (generate_count),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
  endtask

  typedef struct {
    logic       mode;
    logic [15:0] seed;
    int         target;
    logic [7:0] first_c;
    logic [7:0] last_c;
  } vec_t;

  vec_t vecs[6];

  // Start a run with out_ready held high and check it end to end.
  task automatic run_vec(input vec_t v, input string tag);
    int         nvalid   = 0;
    int         done_at  = 0;
    logic [7:0] first_c  = 8'h00;
    logic [7:0] last_c   = 8'h00;
    logic [COUNT_W-1:0] cnt_at_done = '0;
    logic       busy_at_done  = 1'b1;
    logic       valid_at_done = 1'b1;
    @(negedge clk);
    mode = v.mode; seed = v.seed; target_count = COUNT_W'(v.target);
    execute = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    execute = 1'b0;
    for (int obs = 1; obs <= 200 && done_at == 0; obs++) begin
      if (out_valid) begin
        if (nvalid == 0) first_c = generated_ascii;
        last_c = generated_ascii;
        if (v.mode == 1'b0) chk({tag, "_seqchar"}, 32'(generated_ascii), 32'(8'h61 + 8'(nvalid % 26)));
        nvalid++;
      end
      if (done) begin
        done_at = obs; cnt_at_done = generate_count;
        busy_at_done = busy; valid_at_done = out_valid;
      end
      @(negedge clk);
    end
    chk({tag, "_done_cycle"}, 32'(done_at), 32'(v.target + 1));
    chk({tag, "_nvalid"}, 32'(nvalid), 32'(v.target));
    chk({tag, "_count_at_done"}, 32'(cnt_at_done), 32'(v.target));
    chk({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
    chk({tag, "_valid_at_done"}, 32'(valid_at_done), 32'd0);
    chk({tag, "_done_width"}, 32'(done), 32'd0);
    chk({tag, "_count_held"}, 32'(generate_count), 32'(v.target));
    if (v.target > 0) begin
      chk({tag, "_first"}, 32'(first_c), 32'(v.first_c));
      chk({tag, "_last"}, 32'(last_c), 32'(v.last_c));
    end
  endtask

  initial begin
    logic [3:0] pat;
    logic       prev_valid;
    logic       prev_ready;
    logic [7:0] prev_char;
    int         nacc;
    int         ndone;
    bit         fin;
    vec_t       v3;

    // {mode, seed, target, first char, last char}
    vecs[0] = '{1'b0, 16'h0000, 30, 8'h61, 8'h64};  // a..z then a..d
    vecs[1] = '{1'b1, 16'h0000, 1,  8'h72, 8'h72};  // default seed: 0xE1 mod 26 = 17 -> 'r'
    vecs[2] = '{1'b1, 16'h0001, 3,  8'h62, 8'h65};  // 0x01,0x02,0x04 -> b,c,e
    vecs[3] = '{1'b1, 16'h00FF, 2,  8'h76, 8'h75};  // 0xFF->21 'v', 0x01FE low 0xFE->20 'u'
    vecs[4] = '{1'b0, 16'h1234, 26, 8'h61, 8'h7A};  // ends exactly on CHAR_MAX
    vecs[5] = '{1'b0, 16'h0000, 0,  8'h00, 8'h00};  // empty run

    reset = 1'b1; execute = 1'b0; abort = 1'b0; mode = 1'b0;
    seed = 16'h0; target_count = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ascii", 32'(generated_ascii), 32'h61);
    chk("rst_count", 32'(generate_count), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: out_ready follows 1,0,0,1 repeating; sequential, target 8.
    pat = 4'b1001;
    @(negedge clk);
    mode = 1'b0; target_count = COUNT_W'(8); execute = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    execute = 1'b0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_char = 8'h00; nacc = 0; fin = 1'b0;
    for (int c = 0; c < 200 && !fin; c++) begin
      if (out_valid && prev_valid && !prev_ready)
        chk("bp_stall_stable", 32'(generated_ascii), 32'(prev_char));
      if (done) fin = 1'b1;
      out_ready = pat[c % 4];
      if (out_valid && out_ready) begin
        chk("bp_accepted_char", 32'(generated_ascii), 32'(8'h61 + 8'(nacc)));
        nacc++;
      end
      prev_valid = out_valid; prev_ready = out_ready; prev_char = generated_ascii;
      @(negedge clk);
    end
    chk("bp_finished", 32'(fin), 32'd1);
    chk("bp_naccepted", 32'(nacc), 32'd8);
    chk("bp_count", 32'(generate_count), 32'd8);
    out_ready = 1'b1;

    // Reset asserted mid-run after 5 transfers, then a fresh 3-character run.
    @(negedge clk);
    mode = 1'b0; target_count = COUNT_W'(20); execute = 1'b1;
    @(negedge clk);
    execute = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_pre_count", 32'(generate_count), 32'd5);
    chk("mid_pre_busy", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ascii", 32'(generated_ascii), 32'h61);
    chk("mid_rst_count", 32'(generate_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    v3 = '{1'b0, 16'h0000, 3, 8'h61, 8'h63};
    run_vec(v3, "post_rst");

    // Execute pulsed during RUN is ignored; abort after 4 transfers.
    ndone = 0;
    @(negedge clk);
    mode = 1'b0; target_count = COUNT_W'(10); execute = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    execute = 1'b0;
    for (int obs = 1; obs <= 5; obs++) begin
      if (done) ndone++;
      if (obs == 2) execute = 1'b1;
      if (obs == 3) execute = 1'b0;
      if (obs == 5) begin
        chk("abort_pre_count", 32'(generate_count), 32'd4);
        chk("abort_pre_ascii", 32'(generated_ascii), 32'h65);
        abort = 1'b1; out_ready = 1'b0;
      end
      @(negedge clk);
    end
    abort = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_count", 32'(generate_count), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    // Abort together with execute in IDLE: nothing starts.
    mode = 1'b0; target_count = COUNT_W'(5); execute = 1'b1; abort = 1'b1;
    @(negedge clk);
    execute = 1'b0; abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'd0);
    chk("idle_abort_valid", 32'(out_valid), 32'd0);
    chk("idle_abort_done", 32'(done), 32'd0);
    chk("idle_abort_count", 32'(generate_count), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
